// File: rtl/lightsout_pkg.sv
// Shared types and helpers for the lights-out matrix scan scheduler.
package lightsout_pkg;

  localparam int NCOLS_DEF = 3;
  localparam int NROWS_DEF = 3;
  localparam int KEY_W     = 4;

  typedef enum logic [0:0] {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  function automatic logic [KEY_W-1:0] key_idx(input int r, input int c, input int ncols);
    key_idx = KEY_W'(r * ncols + c);
  endfunction

endpackage

// File: rtl/lightsout_key_debounce.sv
// Per-key debouncer: the stable state flips after DEB_SAMPLES consecutive differing samples.
module lightsout_key_debounce
  import lightsout_pkg::*;
#(
  parameter int DEB_SAMPLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_stb,
  input  logic sample_bit,
  output logic stable,
  output logic rise,
  output logic fall
);

  logic       stable_r;
  logic [3:0] cnt_r;
  logic       flip_s;

  // The qualifying sample is the one that would take the count to DEB_SAMPLES.
  always_comb begin
    flip_s = 1'b0;
    if (sample_stb && (sample_bit != stable_r) && (cnt_r == 4'(DEB_SAMPLES - 1))) begin
      flip_s = 1'b1;
    end else begin
      flip_s = 1'b0;
    end
  end

  // Stable bit and run-length counter; only sample strobes advance them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_r <= 1'b0;
      cnt_r    <= 4'd0;
    end else if (sample_stb) begin
      if (sample_bit == stable_r) begin
        cnt_r <= 4'd0;
      end else if (flip_s) begin
        stable_r <= ~stable_r;
        cnt_r    <= 4'd0;
      end else begin
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end

  assign stable = stable_r;
  assign rise   = flip_s & ~stable_r;
  assign fall   = flip_s & stable_r;

endmodule

// File: rtl/lightsout_scan_sched.sv
// Lights-out matrix scan scheduler: column strobes, latched LED rows, debounced key events.
// Optional release events are built when LIGHTSOUT_SCAN_RELEASE_EVT_EN is defined.
module lightsout_scan_sched
  import lightsout_pkg::*;
#(
  parameter int NCOLS        = NCOLS_DEF,
  parameter int NROWS        = NROWS_DEF,
  parameter int DWELL_CYCLES = 64,
  parameter int BLANK_CYCLES = 4,
  parameter int DEB_SAMPLES  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   scan_en,
  input  logic [NROWS*NCOLS-1:0] led_frame,
  input  logic [NROWS-1:0]       btn_row,
  output logic [NCOLS-1:0]       col_drv,
  output logic [NROWS-1:0]       row_drv,
  output logic                   frame_start,
  output logic                   evt_valid,
  output logic [KEY_W-1:0]       evt_key,
  output logic                   evt_release,
  input  logic                   evt_ready,
  output logic                   evt_ovf,
  input  logic                   ovf_clr
);

  localparam int NKEYS  = NROWS * NCOLS;
  localparam int PH_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX);
  localparam int CW     = $clog2(NCOLS);

  scan_state_e state_r, state_s;
  logic [CW-1:0]   col_r, col_s;
  logic [PH_W-1:0] phase_r, phase_s;

  logic drive_s, fs_s, samp_stb_s;
  logic [NKEYS-1:0] frame_q_r, frame_view_s;
  logic [NCOLS-1:0] col_drv_r;
  logic [NROWS-1:0] row_drv_r, row_s, sync1_r, sync2_r;
  logic             frame_start_r;

  logic [NKEYS-1:0] stable_s, rise_s, fall_s, rel_set_s;
  logic [NKEYS-1:0] press_pend_r, rel_pend_r, press_nx_s, rel_nx_s, press_pop_s, rel_pop_s;
  logic [KEY_W-1:0] low_press_s, low_rel_s, key_s, hold_key_r;
  logic             any_press_s, any_rel_s, rel_s, pop_s, ovf_set_s;
  logic             evt_valid_r, evt_ovf_r, hold_r, hold_rel_r;
  logic             unused_s;

  // Scan FSM next state; a low scan_en parks it at the start of a frame.
  always_comb begin
    state_s = state_r;
    col_s   = col_r;
    phase_s = phase_r;
    if (!scan_en) begin
      state_s = BLANK;
      col_s   = {CW{1'b0}};
      phase_s = {PH_W{1'b0}};
    end else begin
      case (state_r)
        BLANK: begin
          if (phase_r == PH_W'(BLANK_CYCLES - 1)) begin
            state_s = DRIVE;
            phase_s = {PH_W{1'b0}};
          end else begin
            phase_s = phase_r + PH_W'(1);
          end
        end
        DRIVE: begin
          if (phase_r == PH_W'(DWELL_CYCLES - 1)) begin
            state_s = BLANK;
            phase_s = {PH_W{1'b0}};
            col_s   = (col_r == CW'(NCOLS - 1)) ? {CW{1'b0}} : col_r + CW'(1);
          end else begin
            phase_s = phase_r + PH_W'(1);
          end
        end
        default: begin
          state_s = BLANK;
          col_s   = {CW{1'b0}};
          phase_s = {PH_W{1'b0}};
        end
      endcase
    end
  end

  // Scan FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= BLANK;
      col_r   <= {CW{1'b0}};
      phase_r <= {PH_W{1'b0}};
    end else begin
      state_r <= state_s;
      col_r   <= col_s;
      phase_r <= phase_s;
    end
  end

  assign drive_s    = scan_en && (state_r == DRIVE);
  assign fs_s       = scan_en && (state_r == BLANK) && (col_r == {CW{1'b0}}) && (phase_r == {PH_W{1'b0}});
  assign samp_stb_s = drive_s && (phase_r == PH_W'(DWELL_CYCLES - 1));
  // The frame being latched this cycle is already the one to show.
  assign frame_view_s = frame_start_r ? led_frame : frame_q_r;

  // Row pattern for the driven column; all rows dark otherwise.
  always_comb begin
    row_s = {NROWS{1'b1}};
    for (int c = 0; c < NCOLS; c++) begin
      for (int r = 0; r < NROWS; r++) begin
        if (drive_s && (col_r == CW'(c))) begin
          row_s[r] = ~frame_view_s[r*NCOLS + c];
        end else begin
          row_s[r] = row_s[r];
        end
      end
    end
  end

  // Matrix drive outputs, frame latch and button synchronizer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_drv_r     <= {NCOLS{1'b0}};
      row_drv_r     <= {NROWS{1'b1}};
      frame_start_r <= 1'b0;
      frame_q_r     <= {NKEYS{1'b0}};
      sync1_r       <= {NROWS{1'b0}};
      sync2_r       <= {NROWS{1'b0}};
    end else begin
      col_drv_r     <= drive_s ? (NCOLS'(1) << col_r) : {NCOLS{1'b0}};
      row_drv_r     <= row_s;
      frame_start_r <= fs_s;
      if (frame_start_r) begin
        frame_q_r <= led_frame;
      end
      sync1_r <= btn_row;
      sync2_r <= sync1_r;
    end
  end

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    for (genvar c = 0; c < NCOLS; c++) begin : g_col
      lightsout_key_debounce #(.DEB_SAMPLES(DEB_SAMPLES)) u_deb (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample_stb (samp_stb_s && (col_r == CW'(c))),
        .sample_bit (sync2_r[r]),
        .stable     (stable_s[key_idx(r, c, NCOLS)]),
        .rise       (rise_s[key_idx(r, c, NCOLS)]),
        .fall       (fall_s[key_idx(r, c, NCOLS)])
      );
    end
  end

`ifdef LIGHTSOUT_SCAN_RELEASE_EVT_EN
  assign rel_set_s   = fall_s;
  assign evt_release = rel_s;
`else
  assign rel_set_s   = {NKEYS{1'b0}};
  assign evt_release = 1'b0;
`endif
  assign unused_s = ^{stable_s, fall_s};

  // Lowest pending index per class; a held head keeps the offered event steady.
  always_comb begin
    low_press_s = {KEY_W{1'b0}};
    low_rel_s   = {KEY_W{1'b0}};
    for (int k = NKEYS - 1; k >= 0; k--) begin
      if (press_pend_r[k]) low_press_s = KEY_W'(k);
      else                 low_press_s = low_press_s;
      if (rel_pend_r[k])   low_rel_s   = KEY_W'(k);
      else                 low_rel_s   = low_rel_s;
    end
    any_press_s = |press_pend_r;
    any_rel_s   = |rel_pend_r;
    key_s       = hold_r ? hold_key_r : (any_press_s ? low_press_s : low_rel_s);
    rel_s       = hold_r ? hold_rel_r : (~any_press_s & any_rel_s);
    pop_s       = evt_valid_r & evt_ready;
    press_pop_s = {NKEYS{1'b0}};
    rel_pop_s   = {NKEYS{1'b0}};
    if (pop_s && !rel_s) begin
      press_pop_s = NKEYS'(1) << key_s;
    end else if (pop_s) begin
      rel_pop_s = NKEYS'(1) << key_s;
    end else begin
      press_pop_s = {NKEYS{1'b0}};
    end
    press_nx_s = (press_pend_r & ~press_pop_s) | rise_s;
    rel_nx_s   = (rel_pend_r & ~rel_pop_s) | rel_set_s;
    ovf_set_s  = (|(rise_s & press_pend_r & ~press_pop_s)) | (|(rel_set_s & rel_pend_r & ~rel_pop_s));
  end

  // Pending masks, sticky overflow and event head hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pend_r <= {NKEYS{1'b0}};
      rel_pend_r   <= {NKEYS{1'b0}};
      evt_valid_r  <= 1'b0;
      evt_ovf_r    <= 1'b0;
      hold_r       <= 1'b0;
      hold_key_r   <= {KEY_W{1'b0}};
      hold_rel_r   <= 1'b0;
    end else begin
      press_pend_r <= press_nx_s;
      rel_pend_r   <= rel_nx_s;
      evt_valid_r  <= (|press_nx_s) | (|rel_nx_s);
      if (ovf_set_s) begin
        evt_ovf_r <= 1'b1;
      end else if (ovf_clr) begin
        evt_ovf_r <= 1'b0;
      end
      hold_r     <= evt_valid_r & ~evt_ready;
      hold_key_r <= key_s;
      hold_rel_r <= rel_s;
    end
  end

  assign col_drv     = col_drv_r;
  assign row_drv     = row_drv_r;
  assign frame_start = frame_start_r;
  assign evt_valid   = evt_valid_r;
  assign evt_key     = key_s;
  assign evt_ovf     = evt_ovf_r;

endmodule

// File: tb/tb_lightsout_scan_sched.sv
// Directed bench for lightsout_scan_sched with DWELL=8, BLANK=2, DEB=3 (frame = 30 cycles).
`timescale 1ns/1ps
module tb_lightsout_scan_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_en = 1'b1;
  logic [8:0] led_frame = 9'h000;
  logic [2:0] btn_row = 3'b000;
  logic [2:0] col_drv;
  logic [2:0] row_drv;
  logic       frame_start;
  logic       evt_valid;
  logic [3:0] evt_key;
  logic       evt_release;
  logic       evt_ready = 1'b0;
  logic       evt_ovf;
  logic       ovf_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lightsout_scan_sched #(
    .NCOLS(3), .NROWS(3), .DWELL_CYCLES(8), .BLANK_CYCLES(2), .DEB_SAMPLES(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .scan_en(scan_en), .led_frame(led_frame), .btn_row(btn_row),
    .col_drv(col_drv), .row_drv(row_drv), .frame_start(frame_start), .evt_valid(evt_valid),
    .evt_key(evt_key), .evt_release(evt_release), .evt_ready(evt_ready), .evt_ovf(evt_ovf),
    .ovf_clr(ovf_clr)
  );

  task automatic wait_col(input logic [2:0] v);
    int k;
    k = 0;
    while (col_drv !== v && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (col_drv !== v) begin
      n_checks++; n_fail++;
      $display("FAIL wait_col: timed out, col_drv=%b required %b", col_drv, v);
    end
  endtask

  task automatic hold_keys(input logic [2:0] r0, input logic [2:0] r1, input logic [2:0] r2, input int frames);
    logic [2:0] rows [3];
    rows[0] = r0; rows[1] = r1; rows[2] = r2;
    for (int f = 0; f < frames; f++) begin
      for (int c = 0; c < 3; c++) begin
        wait_col(3'b001 << c);
        btn_row = rows[c];
        wait_col(3'b000);
        btn_row = 3'b000;
      end
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (col_drv !== 3'b000) begin n_fail++; $display("FAIL reset_col_drv: got %b expected 000", col_drv); end
    n_checks++; if (row_drv !== 3'b111) begin n_fail++; $display("FAIL reset_row_drv: got %b expected 111", row_drv); end
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start: got %b expected 0", frame_start); end
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL reset_evt_valid: got %b expected 0", evt_valid); end
    n_checks++; if (evt_key !== 4'd0) begin n_fail++; $display("FAIL reset_evt_key: got %0d expected 0", evt_key); end
    n_checks++; if (evt_release !== 1'b0) begin n_fail++; $display("FAIL reset_evt_release: got %b expected 0", evt_release); end
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_evt_ovf: got %b expected 0", evt_ovf); end
    rst_n = 1'b1;
  endtask

  task automatic test_frame_timing();
    for (int n = 1; n <= 61; n++) begin
      int t;
      int p;
      logic [2:0] exp_col;
      @(negedge clk);
      t = (n - 1) % 30;
      p = t % 10;
      exp_col = (p < 2) ? 3'b000 : (3'b001 << (t / 10));
      n_checks++; if (col_drv !== exp_col) begin n_fail++; $display("FAIL timing_col_drv: cycle %0d got %b expected %b", n, col_drv, exp_col); end
      n_checks++; if (frame_start !== (t == 0)) begin n_fail++; $display("FAIL timing_frame_start: cycle %0d got %b expected %b", n, frame_start, (t == 0)); end
      n_checks++; if (row_drv !== 3'b111) begin n_fail++; $display("FAIL timing_row_drv: cycle %0d got %b expected 111", n, row_drv); end
    end
  endtask

  task automatic test_frame_latch();
    repeat (15) @(negedge clk);
    led_frame = 9'h155;
    for (int t = 16; t < 30; t++) begin
      @(negedge clk);
      n_checks++; if (row_drv !== 3'b111) begin n_fail++; $display("FAIL latch_midframe: t=%0d row_drv got %b expected 111", t, row_drv); end
    end
    @(negedge clk);
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL latch_frame_start: got %b expected 1", frame_start); end
    repeat (2) @(negedge clk);
    n_checks++; if (row_drv !== 3'b010) begin n_fail++; $display("FAIL latch_col0: row_drv got %b expected 010", row_drv); end
    repeat (10) @(negedge clk);
    n_checks++; if (row_drv !== 3'b101) begin n_fail++; $display("FAIL latch_col1: row_drv got %b expected 101", row_drv); end
    repeat (10) @(negedge clk);
    n_checks++; if (row_drv !== 3'b010) begin n_fail++; $display("FAIL latch_col2: row_drv got %b expected 010", row_drv); end
  endtask

  task automatic test_press();
    hold_keys(3'b000, 3'b000, 3'b010, 1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL press_after1: evt_valid got %b expected 0", evt_valid); end
    hold_keys(3'b000, 3'b000, 3'b010, 1);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL press_after2: evt_valid got %b expected 0", evt_valid); end
    hold_keys(3'b000, 3'b000, 3'b010, 1);
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL press_valid: got %b expected 1", evt_valid); end
    n_checks++; if (evt_key !== 4'd5) begin n_fail++; $display("FAIL press_key: got %0d expected 5", evt_key); end
    n_checks++; if (evt_release !== 1'b0) begin n_fail++; $display("FAIL press_release: got %b expected 0", evt_release); end
    pop_one();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL press_popped: evt_valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_release();
    hold_keys(3'b000, 3'b000, 3'b000, 3);
`ifdef LIGHTSOUT_SCAN_RELEASE_EVT_EN
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL release_valid: got %b expected 1", evt_valid); end
    n_checks++; if (evt_key !== 4'd5) begin n_fail++; $display("FAIL release_key: got %0d expected 5", evt_key); end
    n_checks++; if (evt_release !== 1'b1) begin n_fail++; $display("FAIL release_flag: got %b expected 1", evt_release); end
    pop_one();
`endif
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL release_idle: evt_valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_glitch();
    hold_keys(3'b000, 3'b001, 3'b000, 2);
    hold_keys(3'b000, 3'b000, 3'b000, 3);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_no_event: evt_valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_two_keys();
    hold_keys(3'b001, 3'b100, 3'b000, 3);
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL two_valid: cycle %0d got %b expected 1", i, evt_valid); end
      n_checks++; if (evt_key !== 4'd0) begin n_fail++; $display("FAIL two_key0_held: cycle %0d got %0d expected 0", i, evt_key); end
      @(negedge clk);
    end
    pop_one();
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL two_second_valid: got %b expected 1", evt_valid); end
    n_checks++; if (evt_key !== 4'd7) begin n_fail++; $display("FAIL two_key7: got %0d expected 7", evt_key); end
    n_checks++; if (evt_release !== 1'b0) begin n_fail++; $display("FAIL two_release: got %b expected 0", evt_release); end
    pop_one();
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL two_empty: evt_valid got %b expected 0", evt_valid); end
    evt_ready = 1'b1;
    hold_keys(3'b000, 3'b000, 3'b000, 5);
    evt_ready = 1'b0;
    @(negedge clk);
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: evt_valid got %b expected 0", evt_valid); end
  endtask

  task automatic test_overflow();
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_initial: got %b expected 0", evt_ovf); end
    hold_keys(3'b000, 3'b010, 3'b000, 3);
    n_checks++; if (evt_key !== 4'd4) begin n_fail++; $display("FAIL ovf_first_key: got %0d expected 4", evt_key); end
    hold_keys(3'b000, 3'b000, 3'b000, 3);
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_before_repress: got %b expected 0", evt_ovf); end
    hold_keys(3'b000, 3'b010, 3'b000, 3);
    n_checks++; if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b expected 1", evt_ovf); end
    n_checks++; if (evt_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: got %b expected 1", evt_valid); end
    n_checks++; if (evt_key !== 4'd4) begin n_fail++; $display("FAIL ovf_key: got %0d expected 4", evt_key); end
    n_checks++; if (evt_release !== 1'b0) begin n_fail++; $display("FAIL ovf_release: got %b expected 0", evt_release); end
    pop_one();
`ifdef LIGHTSOUT_SCAN_RELEASE_EVT_EN
    n_checks++; if (evt_key !== 4'd4 || evt_release !== 1'b1) begin n_fail++; $display("FAIL ovf_rel_evt: key %0d rel %b expected key 4 rel 1", evt_key, evt_release); end
    pop_one();
`endif
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_single_event: evt_valid got %b expected 0", evt_valid); end
    n_checks++; if (evt_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", evt_ovf); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_checks++; if (evt_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_clr: got %b expected 0", evt_ovf); end
  endtask

  task automatic test_scan_en();
    wait_col(3'b010);
    repeat (3) @(negedge clk);
    scan_en = 1'b0;
    @(negedge clk);
    n_checks++; if (col_drv !== 3'b000) begin n_fail++; $display("FAIL scan_off_col: got %b expected 000", col_drv); end
    n_checks++; if (row_drv !== 3'b111) begin n_fail++; $display("FAIL scan_off_row: got %b expected 111", row_drv); end
    repeat (4) @(negedge clk);
    n_checks++; if (col_drv !== 3'b000 || frame_start !== 1'b0) begin n_fail++; $display("FAIL scan_off_hold: col %b fs %b expected 000 0", col_drv, frame_start); end
    scan_en = 1'b1;
    @(negedge clk);
    n_checks++; if (frame_start !== 1'b1) begin n_fail++; $display("FAIL scan_on_fs: got %b expected 1", frame_start); end
    @(negedge clk);
    n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL scan_on_fs_pulse: got %b expected 0", frame_start); end
    @(negedge clk);
    n_checks++; if (col_drv !== 3'b001) begin n_fail++; $display("FAIL scan_on_col0: got %b expected 001", col_drv); end
    n_checks++; if (row_drv !== 3'b010) begin n_fail++; $display("FAIL scan_on_row: got %b expected 010", row_drv); end
  endtask

  task automatic test_reset_midop();
    hold_keys(3'b000, 3'b000, 3'b100, 3);
    n_checks++; if (evt_valid !== 1'b1 || evt_key !== 4'd8) begin n_fail++; $display("FAIL midop_pending: valid %b key %0d expected 1 8", evt_valid, evt_key); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (evt_valid !== 1'b0) begin n_fail++; $display("FAIL midop_reset_valid: got %b expected 0", evt_valid); end
    n_checks++; if (col_drv !== 3'b000 || row_drv !== 3'b111) begin n_fail++; $display("FAIL midop_reset_drive: col %b row %b expected 000 111", col_drv, row_drv); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_timing();
    test_frame_latch();
    test_press();
    test_release();
    test_glitch();
    test_two_keys();
    test_overflow();
    test_scan_en();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
